gba_framebuffer_ctrl: RTL and testbench

- Ping-pong frame-buffer controller between the GBA pixel generator (write side) and the VGA scan-out (read side). Drives both buffer0/buffer1 single-port RAMs (17-bit address, 15-bit data, 1-cycle read latency).
- Writer fills the back buffer; reader scans the front buffer. Swap happens only at the reader's vsync, so there is no tearing.
- The writer is back-pressured while a completed frame waits for the swap.

---
 rtl/gba_fb_pkg.sv | 12 +
 rtl/gba_fb_read_pipe.sv | 36 +++
 rtl/gba_framebuffer_ctrl.sv | 121 ++++++++++++
 tb/tb_gba_framebuffer_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gba_fb_pkg.sv
// Shared types and frame geometry for the GBA ping-pong frame buffer.
package gba_fb_pkg;
   localparam int FB_WIDTH  = 240;
   localparam int FB_HEIGHT = 160;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int FB_ADDR_W = 17;
   localparam int FB_DATA_W = 15;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;
   typedef logic [FB_DATA_W-1:0] fb_color_t;
   typedef enum logic {FB_WRITE, FB_PENDING} fb_state_t;
endpackage

// File: rtl/gba_fb_read_pipe.sv
// Two-stage scan-out read pipe: stage 1 latches which buffer was read,
// stage 2 registers that buffer's RAM output.
module gba_fb_read_pipe
   import gba_fb_pkg::*;
#(
   parameter int DATA_W = FB_DATA_W
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              rd_en_i,
   input  logic              sel_i,
   input  logic [DATA_W-1:0] buf0_dout_i,
   input  logic [DATA_W-1:0] buf1_dout_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_color_o
);
   logic [1:0]        vld_pipe_q;
   logic              sel_q;
   logic [DATA_W-1:0] color_q;

   // sel_q is captured at issue, so a later swap cannot redirect a read in flight
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vld_pipe_q <= '0;
         sel_q      <= 1'b0;
         color_q    <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0], rd_en_i};
         if (rd_en_i)       sel_q   <= sel_i;
         if (vld_pipe_q[0]) color_q <= sel_q ? buf1_dout_i : buf0_dout_i;
      end
   end

   assign rd_valid_o = vld_pipe_q[1];
   assign rd_color_o = color_q;
endmodule

// File: rtl/gba_framebuffer_ctrl.sv
// Ping-pong frame-buffer controller: writer fills the back buffer, reader
// scans the front buffer, and buffers swap only at the reader's vsync.
module gba_framebuffer_ctrl
   import gba_fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int NUM_PIXELS = FB_PIXELS
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic [DATA_W-1:0] pix_color,
   input  logic              frame_done,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_vsync,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_color,
   output logic [ADDR_W-1:0] buf0_addr,
   output logic [ADDR_W-1:0] buf1_addr,
   output logic [DATA_W-1:0] buf0_din,
   output logic [DATA_W-1:0] buf1_din,
   output logic              buf0_we,
   output logic              buf1_we,
   input  logic [DATA_W-1:0] buf0_dout,
   input  logic [DATA_W-1:0] buf1_dout,
   output logic              front_sel,
   output logic              swap_pending,
   output logic [7:0]        drop_count,
   output logic              addr_err
);
   fb_state_t         state_q;
   logic              front_sel_q;
   logic [7:0]        drop_count_q;
   logic              addr_err_q;
   logic [ADDR_W-1:0] addr0_q, addr1_q;
   logic              wr_acc, wr_ok;

   assign pix_ready    = (state_q == FB_WRITE);
   assign swap_pending = (state_q == FB_PENDING);
   assign front_sel    = front_sel_q;
   assign drop_count   = drop_count_q;
   assign addr_err     = addr_err_q;

   assign wr_acc = pix_valid & pix_ready;
   assign wr_ok  = wr_acc & (32'(pix_addr) < NUM_PIXELS);

   // Back buffer belongs to the writer, front to the reader; idle ports hold addr.
   always_comb begin
      buf0_we   = 1'b0;
      buf1_we   = 1'b0;
      buf0_din  = '0;
      buf1_din  = '0;
      buf0_addr = addr0_q;
      buf1_addr = addr1_q;
      if (front_sel_q) begin
         if (rd_en) buf1_addr = rd_addr;
         if (wr_ok) begin
            buf0_we   = 1'b1;
            buf0_addr = pix_addr;
            buf0_din  = pix_color;
         end
      end else begin
         if (rd_en) buf0_addr = rd_addr;
         if (wr_ok) begin
            buf1_we   = 1'b1;
            buf1_addr = pix_addr;
            buf1_din  = pix_color;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         addr0_q <= '0;
         addr1_q <= '0;
      end else begin
         addr0_q <= buf0_addr;
         addr1_q <= buf1_addr;
      end
   end

   // A frame_done in WRITE only arms the swap; the vsync that follows performs it.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= FB_WRITE;
         front_sel_q  <= 1'b0;
         drop_count_q <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         if (wr_acc && !wr_ok) addr_err_q <= 1'b1;
         case (state_q)
            FB_WRITE: begin
               if (frame_done) state_q <= FB_PENDING;
            end
            FB_PENDING: begin
               if (frame_done && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
               if (rd_vsync) begin
                  front_sel_q <= ~front_sel_q;
                  state_q     <= FB_WRITE;
               end
            end
            default: state_q <= FB_WRITE;
         endcase
      end
   end

   gba_fb_read_pipe #(.DATA_W(DATA_W)) u_read_pipe (
      .clk         (clk),
      .rst_b       (rst_b),
      .rd_en_i     (rd_en),
      .sel_i       (front_sel_q),
      .buf0_dout_i (buf0_dout),
      .buf1_dout_i (buf1_dout),
      .rd_valid_o  (rd_valid),
      .rd_color_o  (rd_color)
   );
endmodule

// File: tb/tb_gba_framebuffer_ctrl.sv
// Randomised bench for gba_framebuffer_ctrl against a frame-level reference model.
module tb_gba_framebuffer_ctrl;
   localparam int NPIX  = 38400;
   localparam int MEMSZ = 131072;

   logic        clk = 1'b0, rst_b = 1'b0;
   logic        pix_valid = 1'b0, frame_done = 1'b0, rd_en = 1'b0, rd_vsync = 1'b0;
   logic [16:0] pix_addr = '0, rd_addr = '0;
   logic [14:0] pix_color = '0;
   logic        pix_ready, rd_valid, buf0_we, buf1_we, front_sel, swap_pending, addr_err;
   logic [14:0] rd_color, buf0_din, buf1_din;
   logic [14:0] buf0_dout = '0, buf1_dout = '0;
   logic [16:0] buf0_addr, buf1_addr;
   logic [7:0]  drop_count;

   gba_framebuffer_ctrl dut (
      .clk(clk), .rst_b(rst_b), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_addr(pix_addr), .pix_color(pix_color), .frame_done(frame_done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_vsync(rd_vsync), .rd_valid(rd_valid),
      .rd_color(rd_color), .buf0_addr(buf0_addr), .buf1_addr(buf1_addr),
      .buf0_din(buf0_din), .buf1_din(buf1_din), .buf0_we(buf0_we), .buf1_we(buf1_we),
      .buf0_dout(buf0_dout), .buf1_dout(buf1_dout), .front_sel(front_sel),
      .swap_pending(swap_pending), .drop_count(drop_count), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   // Single-port RAMs with 1-cycle read latency
   logic [14:0] ram0 [MEMSZ];
   logic [14:0] ram1 [MEMSZ];
   int n_we0 = 0, n_we1 = 0;
   always @(posedge clk) begin
      buf0_dout <= ram0[buf0_addr];
      buf1_dout <= ram1[buf1_addr];
      if (buf0_we) begin ram0[buf0_addr] = buf0_din; n_we0++; end
      if (buf1_we) begin ram1[buf1_addr] = buf1_din; n_we1++; end
   end

   // Reference model: which buffer is shown, whether a frame waits, and buffer images
   typedef struct { int due; logic [14:0] c; } rd_t;
   rd_t         rq[$];
   logic [14:0] sh [2][MEMSZ];
   logic [16:0] m_last [2];
   bit          m_front, m_pend, m_err;
   int          m_drop, cyc;
   int          n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] baddr(input int b);
      return (b != 0) ? buf1_addr : buf0_addr;
   endfunction
   function automatic logic [14:0] bdin(input int b);
      return (b != 0) ? buf1_din : buf0_din;
   endfunction
   function automatic logic bwe(input int b);
      return (b != 0) ? buf1_we : buf0_we;
   endfunction

   task automatic model_reset();
      m_front = 0; m_pend = 0; m_err = 0; m_drop = 0;
      m_last[0] = '0; m_last[1] = '0;
      rq.delete();
   endtask

   task automatic idle();
      pix_valid = 0; frame_done = 0; rd_en = 0; rd_vsync = 0;
   endtask

   // One clock: check RAM port drive, advance model at the edge, check registered outputs
   task automatic tick();
      int  bk, fr;
      bit  wr;
      #1;
      bk = m_front ? 0 : 1;
      fr = 1 - bk;
      wr = !m_pend && pix_valid && (int'(pix_addr) < NPIX);
      chk("we_back", 32'(bwe(bk)), 32'(wr));
      chk("we_front", 32'(bwe(fr)), 32'(0));
      chk("din_front", 32'(bdin(fr)), 32'(0));
      if (wr) begin
         chk("addr_back", 32'(baddr(bk)), 32'(pix_addr));
         chk("din_back", 32'(bdin(bk)), 32'(pix_color));
         m_last[bk] = pix_addr;
      end else begin
         chk("hold_back", 32'(baddr(bk)), 32'(m_last[bk]));
         chk("din_back_idle", 32'(bdin(bk)), 32'(0));
      end
      if (rd_en) begin
         chk("addr_front", 32'(baddr(fr)), 32'(rd_addr));
         m_last[fr] = rd_addr;
      end else chk("hold_front", 32'(baddr(fr)), 32'(m_last[fr]));
      @(posedge clk);
      if (!m_pend && pix_valid) begin
         if (int'(pix_addr) < NPIX) sh[bk][pix_addr] = pix_color;
         else m_err = 1;
      end
      if (rd_en) rq.push_back('{cyc + 2, sh[fr][rd_addr]});
      if (!m_pend) begin
         if (frame_done) m_pend = 1;
      end else begin
         if (frame_done && m_drop < 255) m_drop++;
         if (rd_vsync) begin m_front = !m_front; m_pend = 0; end
      end
      cyc++;
      #1;
      chk("pix_ready", 32'(pix_ready), 32'(!m_pend));
      chk("swap_pending", 32'(swap_pending), 32'(m_pend));
      chk("front_sel", 32'(front_sel), 32'(m_front));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("addr_err", 32'(addr_err), 32'(m_err));
      if (rq.size() > 0 && rq[0].due == cyc) begin
         chk("rd_valid", 32'(rd_valid), 32'(1));
         chk("rd_color", 32'(rd_color), 32'(rq[0].c));
         void'(rq.pop_front());
      end else chk("rd_valid_idle", 32'(rd_valid), 32'(0));
   endtask

   initial begin
      int w0, w1;
      for (int i = 0; i < MEMSZ; i++) begin
         ram0[i] = '0; ram1[i] = '0; sh[0][i] = '0; sh[1][i] = '0;
      end
      model_reset();
      cyc = 0;
      #2;
      chk("rst_pix_ready", 32'(pix_ready), 32'(1));
      chk("rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("rst_front_sel", 32'(front_sel), 32'(0));
      chk("rst_swap_pending", 32'(swap_pending), 32'(0));
      chk("rst_drop_count", 32'(drop_count), 32'(0));
      chk("rst_addr_err", 32'(addr_err), 32'(0));
      chk("rst_we", 32'({buf0_we, buf1_we}), 32'(0));
      @(posedge clk); #1 rst_b = 1;

      // Full frame into buffer 1, frame_done with the last pixel
      n_we0 = 0; n_we1 = 0;
      for (int i = 0; i < NPIX; i++) begin
         pix_valid = 1; pix_addr = 17'(i); pix_color = 15'(i);
         frame_done = (i == NPIX - 1);
         tick();
      end
      idle();
      chk("frame_we1_pulses", 32'(n_we1), 32'(NPIX));
      chk("frame_we0_pulses", 32'(n_we0), 32'(0));
      chk("ready_after_done", 32'(pix_ready), 32'(0));
      chk("pending_after_done", 32'(swap_pending), 32'(1));

      // Swap, then single read of addr 100 from buffer 1
      rd_vsync = 1; tick(); rd_vsync = 0;
      chk("front_after_vsync", 32'(front_sel), 32'(1));
      rd_en = 1; rd_addr = 17'd100; tick(); rd_en = 0;
      chk("rd100_not_yet", 32'(rd_valid), 32'(0));
      tick();
      chk("rd100_valid", 32'(rd_valid), 32'(1));
      chk("rd100_color", 32'(rd_color), 32'(100));

      // Mark buffer 0, then burst-read 0..9 across a swap
      for (int i = 0; i < 10; i++) begin
         pix_valid = 1; pix_addr = 17'(i); pix_color = 15'(16'h4000 | 16'(i)); tick();
      end
      idle(); frame_done = 1; tick(); frame_done = 0;
      for (int i = 0; i < 10; i++) begin
         rd_en = 1; rd_addr = 17'(i); rd_vsync = (i == 5); tick();
      end
      idle(); tick(); tick();
      chk("burst_front", 32'(front_sel), 32'(0));
      chk("burst_drained", 32'(rq.size()), 32'(0));

      // Dropped frames and saturation
      frame_done = 1; tick(); tick(); tick();
      frame_done = 0;
      chk("drop_two", 32'(drop_count), 32'(2));
      frame_done = 1;
      for (int i = 0; i < 300; i++) tick();
      frame_done = 0;
      chk("drop_sat", 32'(drop_count), 32'(255));
      rd_vsync = 1; tick(); rd_vsync = 0;

      // Out-of-range writes
      w0 = n_we0; w1 = n_we1;
      pix_valid = 1; pix_addr = 17'h09600; pix_color = 15'h7fff; tick();
      pix_addr = 17'h1ffff; tick();
      idle();
      chk("oob_no_we", 32'((n_we0 - w0) + (n_we1 - w1)), 32'(0));
      chk("oob_err", 32'(addr_err), 32'(1));
      tick(); tick();
      chk("oob_err_sticky", 32'(addr_err), 32'(1));

      // frame_done and vsync together in WRITE: arm only
      w0 = int'(front_sel);
      frame_done = 1; rd_vsync = 1; tick(); idle();
      chk("coinc_no_swap", 32'(front_sel), 32'(w0));
      chk("coinc_pending", 32'(swap_pending), 32'(1));
      rd_vsync = 1; tick(); rd_vsync = 0;
      chk("coinc_next_swap", 32'(front_sel), 32'(w0 == 0));

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         pix_valid  = 1'($urandom_range(0, 1));
         pix_addr   = ($urandom_range(0, 15) == 0) ? 17'(NPIX + $urandom_range(0, MEMSZ - 1 - NPIX))
                                                   : 17'($urandom_range(0, NPIX - 1));
         pix_color  = 15'($urandom);
         frame_done = ($urandom_range(0, 39) == 0);
         rd_vsync   = ($urandom_range(0, 29) == 0);
         rd_en      = 1'($urandom_range(0, 1));
         rd_addr    = 17'($urandom_range(0, NPIX - 1));
         tick();
      end
      idle(); tick(); tick();

      // Reset mid-burst with buffer 1 in front
      for (int k = 0; k < 4 && !m_front; k++) begin
         if (!m_pend) begin frame_done = 1; tick(); frame_done = 0; end
         rd_vsync = 1; tick(); rd_vsync = 0;
      end
      chk("pre_rst_front", 32'(front_sel), 32'(1));
      for (int i = 0; i < 3; i++) begin rd_en = 1; rd_addr = 17'(200 + i); tick(); end
      rst_b = 0; idle();
      #1;
      chk("arst_rd_valid", 32'(rd_valid), 32'(0));
      chk("arst_front_sel", 32'(front_sel), 32'(0));
      chk("arst_pix_ready", 32'(pix_ready), 32'(1));
      chk("arst_drop_count", 32'(drop_count), 32'(0));
      model_reset();
      @(posedge clk); @(posedge clk); #1 rst_b = 1;
      for (int i = 0; i < 6; i++) begin rd_en = 1; rd_addr = 17'(i); tick(); end
      idle(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
